cpu_mem_responder: RTL and testbench
====================================

// Module: cpu_mem_responder
// PURPOSE
//  Responder end of the CPU memory bus: a 2^ADDR_W x DATA_W unified instruction/data store.
//  Serves the CPU's fetch, operand-read and STO-write requests over a req/ack handshake.
//  Inserts a programmable number of wait states per access.
//  A host loader port downloads programs and data; it replaces hierarchical memory pokes in benches.
// PARAMETERS
//  ADDR_W       5  address width; depth = 2**ADDR_W words (matches the 5-bit operand field)
//  DATA_W       8  word width (3-bit opcode + 5-bit operand)
//  WAIT_STATES  0  extra cycles between request acceptance and ack; legal range 0..15
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       synchronous, active-low reset
//  cpu_req    in   1       CPU access request; held high until cpu_ack
//  cpu_we     in   1       1 = write (STO), 0 = read (fetch/operand)
//  cpu_addr   in   ADDR_W  access address
//  cpu_wdata  in   DATA_W  write data (accumulator)
//  cpu_rdata  out  DATA_W  read data; valid in the cpu_ack cycle, held until the next read ack
//  cpu_ack    out  1       one-cycle completion pulse
//  busy       out  1       high in WAIT or ACK
//  ld_valid   in   1       host load request
//  ld_addr    in   ADDR_W  load address
//  ld_data    in   DATA_W  load data
//  ld_ready   out  1       high in IDLE; a write occurs when ld_valid & ld_ready
//  cpu_perr   out  1       parity error flag (MEM_PARITY_EN builds only)
// BEHAVIOUR
//  Reset (rst==0 at a clk edge): state=IDLE; cpu_ack=0; cpu_rdata=0; busy=0; cpu_perr=0.
//   ld_ready is 0 while rst is low. Array contents are NOT cleared.
//  Reset mid-transaction aborts the transaction: no array write, no ack.
//  FSM states: IDLE, WAIT, ACK. cpu_ack=(state==ACK); busy=(state!=IDLE); ld_ready=(state==IDLE)&rst.
//  IDLE:
//   - ld_valid: write ld_data to ld_addr this edge; stay IDLE. Loader has priority.
//   - else if cpu_req: latch addr/we/wdata; cnt<=WAIT_STATES.
//     Next state is ACK if WAIT_STATES==0, else WAIT.
//  WAIT:
//   - cpu_req==0: abort; go to IDLE with no write and no ack.
//   - else cnt decrements each cycle; cnt==1 -> ACK.
//  ACK:
//   - write: array[addr]<=wdata at the ACK-entry edge (committed; not abortable).
//   - read: cpu_rdata loaded from array[addr] at the ACK-entry edge.
//   - Next state is always IDLE.
//   - cpu_req still high in the IDLE cycle that follows starts a new access (back-to-back allowed).
//  Latency: if req is sampled at edge N, cpu_ack is high during cycle N+1+WAIT_STATES.
//  Simultaneous ld_valid & cpu_req in IDLE: load wins; the CPU is accepted on the next IDLE cycle.
//  Read after write to the same address returns the new data. No read-modify hazards: one access in flight.
//  Address wrap: none needed; every ADDR_W value maps to a valid word.
// CONFIGURATION
//  MEM_PARITY_EN defined:
//   - array stores DATA_W+1 bits (even parity computed on every CPU or loader write).
//   - In the read ACK cycle, cpu_perr=1 if stored parity mismatches; otherwise 0.
//   - cpu_perr is sticky-free: it updates on every read ack.
//  MEM_PARITY_EN undefined: array is DATA_W bits; the cpu_perr port is absent.
// STRUCTURE
//  risc_cpu_pkg:
//   - ADDR_W/DATA_W defaults
//   - opcode constants (HLT=3'b000, ADD=3'b010, LDA=3'b101, STO=3'b110)
//   - responder state encoding
//  Sub-module mem_array: 1 write port (muxed CPU/loader), 1 synchronous read port.
//  Parity bit and its generation live in mem_array under MEM_PARITY_EN.
//  FSM, wait counter and loader arbitration stay in cpu_mem_responder.
// TESTING
//  1 Load 0xB4,0x55,0xD6,0x00 @0..3 and 0x05@20, 0x03@21 via the loader.
//    -> CPU reads of 0..3,20,21 return exactly those values.
//  2 WAIT_STATES=2, read addr 20 with req at edge N.
//    -> cpu_ack high only in cycle N+3; cpu_rdata=0x05; busy high for cycles N+1..N+3.
//  3 Write 0x08 to addr 22, then read 22 back-to-back.
//    -> second ack returns 0x08; word 21 is still 0x03.
//  4 WAIT_STATES=3, write 0xFF to addr 22 and drop req in WAIT.
//    -> no ack; back to IDLE; word 22 unchanged (0x08).
//  5 ld_valid and cpu_req asserted in the same IDLE cycle (ld 0x11@5; CPU read of 5).
//    -> load is taken first; the CPU read acks with 0x11.
//  6 rst low during WAIT of a write 0x77@7.
//    -> cpu_ack=0, cpu_rdata=0, word 7 unchanged.
//    With MEM_PARITY_EN: flip the stored bit of word 20 -> read ack shows cpu_perr=1.

Source files
------------

// File: rtl/risc_cpu_pkg.sv
// Shared constants for the accumulator CPU and its memory responder.
package risc_cpu_pkg;

    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned DATA_W_DEF = 8;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } resp_state_e;

endpackage

// File: rtl/mem_array.sv
// Unified instruction/data store: one muxed write port, one registered read port.
// With MEM_PARITY_EN each word carries an even-parity bit checked on read.
module mem_array
    import risc_cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
`ifdef MEM_PARITY_EN
    ,
    output logic              o_perr
`endif
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
`ifdef MEM_PARITY_EN
    localparam int unsigned WORD_W = DATA_W + 1;
`else
    localparam int unsigned WORD_W = DATA_W;
`endif

    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [WORD_W-1:0] w_wword;
    logic [WORD_W-1:0] w_rword;
    logic [DATA_W-1:0] r_rdata;

`ifdef MEM_PARITY_EN
    logic r_perr;
    assign w_wword = {^i_wdata, i_wdata};
`else
    assign w_wword = i_wdata;
`endif

    assign w_rword = r_mem[i_raddr];

    // Storage is intentionally not reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= w_wword;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= w_rword[DATA_W-1:0];
        end
    end

`ifdef MEM_PARITY_EN
    // Stored word {p, d} with p = ^d reduces to 0 when intact.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_perr <= 1'b0;
        end else if (i_re) begin
            r_perr <= ^w_rword;
        end
    end

    assign o_perr = r_perr;
`endif

    assign o_rdata = r_rdata;

endmodule

// File: rtl/cpu_mem_responder.sv
// CPU memory-bus responder: req/ack handshake with programmable wait states plus a host loader.
// Optional MEM_PARITY_EN adds the cpu_perr flag backed by per-word parity in mem_array.
module cpu_mem_responder
    import risc_cpu_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              busy,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready
`ifdef MEM_PARITY_EN
    ,
    output logic              cpu_perr
`endif
);

    localparam int unsigned CNT_W   = 4;
    localparam bit          NO_WAIT = (WAIT_STATES == 0);

    resp_state_e       r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [DATA_W-1:0] r_wdata;
    logic              r_ack;
    logic              r_busy;

    logic              w_idle;
    logic              w_ld_fire;
    logic              w_accept;
    logic              w_wait_done;
    logic              w_go_ack;
    logic [ADDR_W-1:0] w_acc_addr;
    logic              w_acc_we;
    logic [DATA_W-1:0] w_acc_wdata;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_waddr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic              w_mem_re;

    assign w_idle      = (r_state == ST_IDLE);
    assign ld_ready    = w_idle & rst;
    assign w_ld_fire   = ld_valid & ld_ready;
    assign w_accept    = w_idle & rst & ~ld_valid & cpu_req;
    assign w_wait_done = (r_state == ST_WAIT) & rst & cpu_req & (r_cnt == CNT_W'(1));
    assign w_go_ack    = (w_accept & NO_WAIT) | w_wait_done;

    // With zero wait states the access is performed on the acceptance edge itself.
    assign w_acc_addr  = w_idle ? cpu_addr  : r_addr;
    assign w_acc_we    = w_idle ? cpu_we    : r_we;
    assign w_acc_wdata = w_idle ? cpu_wdata : r_wdata;

    assign w_mem_we    = w_ld_fire | (w_go_ack & w_acc_we);
    assign w_mem_waddr = w_ld_fire ? ld_addr : w_acc_addr;
    assign w_mem_wdata = w_ld_fire ? ld_data : w_acc_wdata;
    assign w_mem_re    = w_go_ack & ~w_acc_we;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_addr  <= cpu_addr;
                        r_we    <= cpu_we;
                        r_wdata <= cpu_wdata;
                        r_cnt   <= CNT_W'(WAIT_STATES);
                        r_state <= NO_WAIT ? ST_ACK : ST_WAIT;
                        r_ack   <= NO_WAIT;
                        r_busy  <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (!cpu_req) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == CNT_W'(1)) begin
                        r_state <= ST_ACK;
                        r_ack   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_ACK: begin
                    r_state <= ST_IDLE;
                    r_ack   <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ack   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_mem_we),
        .i_waddr (w_mem_waddr),
        .i_wdata (w_mem_wdata),
        .i_re    (w_mem_re),
        .i_raddr (w_acc_addr),
        .o_rdata (cpu_rdata)
`ifdef MEM_PARITY_EN
        ,
        .o_perr  (cpu_perr)
`endif
    );

    assign cpu_ack = r_ack;
    assign busy    = r_busy;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Scoreboard bench for cpu_mem_responder: three instances with 0, 2 and 3 wait states.
`timescale 1ns/1ps
module tb_cpu_mem_responder;

    localparam int NI  = 3;
    localparam int WS0 = 0;
    localparam int WS1 = 2;
    localparam int WS2 = 3;

    typedef struct {
        int         inst;
        bit         we;
        logic [4:0] addr;
        logic [7:0] data;
        bit         perr;
        int         issue;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst       [NI];
    logic       cpu_req   [NI];
    logic       cpu_we    [NI];
    logic [4:0] cpu_addr  [NI];
    logic [7:0] cpu_wdata [NI];
    logic [7:0] cpu_rdata [NI];
    logic       cpu_ack   [NI];
    logic       busy      [NI];
    logic       ld_valid  [NI];
    logic [4:0] ld_addr   [NI];
    logic [7:0] ld_data   [NI];
    logic       ld_ready  [NI];
`ifdef MEM_PARITY_EN
    logic       cpu_perr  [NI];
`endif

    logic [7:0] mdl     [NI][32];
    bit         corrupt [NI][32];
    exp_t       sb_q [$];
    exp_t       mon_e;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cpu_mem_responder #(.ADDR_W(5), .DATA_W(8), .WAIT_STATES(WS0)) u0 (
        .clk(clk), .rst(rst[0]), .cpu_req(cpu_req[0]), .cpu_we(cpu_we[0]),
        .cpu_addr(cpu_addr[0]), .cpu_wdata(cpu_wdata[0]), .cpu_rdata(cpu_rdata[0]),
        .cpu_ack(cpu_ack[0]), .busy(busy[0]), .ld_valid(ld_valid[0]),
        .ld_addr(ld_addr[0]), .ld_data(ld_data[0]), .ld_ready(ld_ready[0])
`ifdef MEM_PARITY_EN
        , .cpu_perr(cpu_perr[0])
`endif
    );

    cpu_mem_responder #(.ADDR_W(5), .DATA_W(8), .WAIT_STATES(WS1)) u1 (
        .clk(clk), .rst(rst[1]), .cpu_req(cpu_req[1]), .cpu_we(cpu_we[1]),
        .cpu_addr(cpu_addr[1]), .cpu_wdata(cpu_wdata[1]), .cpu_rdata(cpu_rdata[1]),
        .cpu_ack(cpu_ack[1]), .busy(busy[1]), .ld_valid(ld_valid[1]),
        .ld_addr(ld_addr[1]), .ld_data(ld_data[1]), .ld_ready(ld_ready[1])
`ifdef MEM_PARITY_EN
        , .cpu_perr(cpu_perr[1])
`endif
    );

    cpu_mem_responder #(.ADDR_W(5), .DATA_W(8), .WAIT_STATES(WS2)) u2 (
        .clk(clk), .rst(rst[2]), .cpu_req(cpu_req[2]), .cpu_we(cpu_we[2]),
        .cpu_addr(cpu_addr[2]), .cpu_wdata(cpu_wdata[2]), .cpu_rdata(cpu_rdata[2]),
        .cpu_ack(cpu_ack[2]), .busy(busy[2]), .ld_valid(ld_valid[2]),
        .ld_addr(ld_addr[2]), .ld_data(ld_data[2]), .ld_ready(ld_ready[2])
`ifdef MEM_PARITY_EN
        , .cpu_perr(cpu_perr[2])
`endif
    );

    function automatic int ws_of(input int i);
        case (i)
            0:       return WS0;
            1:       return WS1;
            default: return WS2;
        endcase
    endfunction

    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s inst%0d: got 0x%0h expected 0x%0h (t=%0t)", name, i, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every ack must match the oldest outstanding request.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (cpu_ack[i] === 1'b1) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_ack", i, 1, 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("ack_inst", i, i, mon_e.inst);
                    chk("ack_latency", i, cyc, mon_e.issue + ws_of(i));
                    if (!mon_e.we) begin
                        chk("rdata", i, cpu_rdata[i], mon_e.data);
`ifdef MEM_PARITY_EN
                        chk("perr", i, cpu_perr[i], mon_e.perr);
`endif
                    end
                end
            end
        end
    end

    task automatic do_load(input int i, input logic [4:0] a, input logic [7:0] d);
        cpu_req[i]  = 1'b0;
        ld_valid[i] = 1'b1;
        ld_addr[i]  = a;
        ld_data[i]  = d;
        #1;
        chk("ld_ready", i, ld_ready[i], 1);
        mdl[i][a]     = d;
        corrupt[i][a] = 1'b0;
        tick();
        ld_valid[i] = 1'b0;
    endtask

    // Issue one CPU access (optionally racing a load); returns one cycle after its ack.
    task automatic cpu_access(input int i, input bit we, input logic [4:0] a, input logic [7:0] d,
                              input bit keep, input bit ld_en, input logic [4:0] la, input logic [7:0] ldd);
        exp_t e;
        int   start;
        int   budget;
        bit   got;
        start = cyc;
        if (ld_en) begin
            ld_valid[i]    = 1'b1;
            ld_addr[i]     = la;
            ld_data[i]     = ldd;
            mdl[i][la]     = ldd;
            corrupt[i][la] = 1'b0;
        end
        cpu_req[i]   = 1'b1;
        cpu_we[i]    = we;
        cpu_addr[i]  = a;
        cpu_wdata[i] = d;
        e.inst  = i;
        e.we    = we;
        e.addr  = a;
        e.issue = start + 1 + (ld_en ? 1 : 0);
        if (we) begin
            mdl[i][a]     = d;
            corrupt[i][a] = 1'b0;
        end
        e.data = mdl[i][a];
        e.perr = corrupt[i][a];
        sb_q.push_back(e);
        budget = 0;
        got    = 1'b0;
        while (!got && budget < 40) begin
            @(negedge clk);
            budget++;
            if (cyc > start) ld_valid[i] = 1'b0;
            if (cyc >= e.issue) chk("busy_active", i, busy[i], 1);
            else if (cyc > start) chk("busy_idle", i, busy[i], 0);
            got = (cpu_ack[i] === 1'b1);
        end
        if (!got) chk("ack_timeout", i, 0, 1);
        tick();
        if (!keep) begin
            cpu_req[i] = 1'b0;
            @(negedge clk);
            chk("busy_after", i, busy[i], 0);
            tick();
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [4:0] ra, la;
        logic [7:0] rd, ld;
        int         op;

        for (int i = 0; i < NI; i++) begin
            rst[i] = 1'b0; cpu_req[i] = 1'b0; cpu_we[i] = 1'b0; cpu_addr[i] = '0;
            cpu_wdata[i] = '0; ld_valid[i] = 1'b0; ld_addr[i] = '0; ld_data[i] = '0;
        end
        tick();
        tick();
        for (int i = 0; i < NI; i++) begin
            chk("rst_ack", i, cpu_ack[i], 0);
            chk("rst_rdata", i, cpu_rdata[i], 0);
            chk("rst_busy", i, busy[i], 0);
            chk("rst_ld_ready", i, ld_ready[i], 0);
            rst[i] = 1'b1;
        end
        #1;
        for (int i = 0; i < NI; i++) chk("ld_ready_after_rst", i, ld_ready[i], 1);

        // Known contents everywhere before any read.
        for (int i = 0; i < NI; i++)
            for (int a = 0; a < 32; a++) do_load(i, 5'(a), 8'($urandom_range(0, 255)));

        // Program download and readback.
        for (int i = 0; i < 2; i++) begin
            do_load(i, 5'd0, 8'hB4);
            do_load(i, 5'd1, 8'h55);
            do_load(i, 5'd2, 8'hD6);
            do_load(i, 5'd3, 8'h00);
            do_load(i, 5'd20, 8'h05);
            do_load(i, 5'd21, 8'h03);
        end
        cpu_access(0, 0, 5'd0, 8'h0, 1, 0, 5'd0, 8'h0);
        cpu_access(0, 0, 5'd1, 8'h0, 1, 0, 5'd0, 8'h0);
        cpu_access(0, 0, 5'd2, 8'h0, 0, 0, 5'd0, 8'h0);
        cpu_access(0, 0, 5'd3, 8'h0, 0, 0, 5'd0, 8'h0);
        cpu_access(0, 0, 5'd20, 8'h0, 1, 0, 5'd0, 8'h0);
        cpu_access(0, 0, 5'd21, 8'h0, 0, 0, 5'd0, 8'h0);

        // Two wait states on a read.
        cpu_access(1, 0, 5'd20, 8'h0, 0, 0, 5'd0, 8'h0);

        // Write then back-to-back readback.
        cpu_access(0, 1, 5'd22, 8'h08, 1, 0, 5'd0, 8'h0);
        cpu_access(0, 0, 5'd22, 8'h0, 1, 0, 5'd0, 8'h0);
        cpu_access(0, 0, 5'd21, 8'h0, 0, 0, 5'd0, 8'h0);

        // Abandoned write in WAIT must leave the word untouched.
        do_load(2, 5'd22, 8'h08);
        cpu_req[2] = 1'b1; cpu_we[2] = 1'b1; cpu_addr[2] = 5'd22; cpu_wdata[2] = 8'hFF;
        tick();
        tick();
        cpu_req[2] = 1'b0;
        tick();
        @(negedge clk);
        chk("abort_busy", 2, busy[2], 0);
        tick();
        cpu_access(2, 0, 5'd22, 8'h0, 0, 0, 5'd0, 8'h0);

        // Load and CPU read in the same IDLE cycle: load first.
        cpu_access(0, 0, 5'd5, 8'h0, 0, 1, 5'd5, 8'h11);

        // Reset during WAIT of a write.
        do_load(2, 5'd7, 8'h3C);
        cpu_access(2, 0, 5'd7, 8'h0, 0, 0, 5'd0, 8'h0);
        cpu_req[2] = 1'b1; cpu_we[2] = 1'b1; cpu_addr[2] = 5'd7; cpu_wdata[2] = 8'h77;
        tick();
        rst[2] = 1'b0;
        tick();
        cpu_req[2] = 1'b0;
        chk("midrst_ack", 2, cpu_ack[2], 0);
        chk("midrst_rdata", 2, cpu_rdata[2], 0);
        chk("midrst_busy", 2, busy[2], 0);
        chk("midrst_ld_ready", 2, ld_ready[2], 0);
        tick();
        rst[2] = 1'b1;
        #1;
        chk("postrst_ld_ready", 2, ld_ready[2], 1);
        tick();
        cpu_access(2, 0, 5'd7, 8'h0, 0, 0, 5'd0, 8'h0);

`ifdef MEM_PARITY_EN
        u1.u_mem.r_mem[20][0] = ~u1.u_mem.r_mem[20][0];
        mdl[1][20]     = mdl[1][20] ^ 8'h01;
        corrupt[1][20] = 1'b1;
        cpu_access(1, 0, 5'd20, 8'h0, 0, 0, 5'd0, 8'h0);
`endif

        // Randomized traffic on every instance.
        for (int i = 0; i < NI; i++) begin
            for (int k = 0; k < 40; k++) begin
                op = int'($urandom_range(0, 9));
                ra = 5'($urandom_range(0, 31));
                rd = 8'($urandom_range(0, 255));
                la = 5'($urandom_range(0, 31));
                ld = 8'($urandom_range(0, 255));
                if (op < 2) do_load(i, ra, rd);
                else cpu_access(i, op < 5, ra, rd, 1'($urandom_range(0, 1)), op == 9, la, ld);
            end
            cpu_req[i] = 1'b0;
            tick();
            tick();
        end

        tick();
        chk("sb_drained", 0, sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
